aximm_incr_chk: RTL and testbench
=================================

# aximm_incr_chk

Incrementing-pattern checker for the AXI-MM full examples. It consumes the word stream produced by the incrementing pattern generator on the far side of the link. Words are drained from the checker FIFO (first-word-fall-through) and compared against a locally generated expected sequence of seed, seed+1, seed+2, and so on. The block reports pass/fail, error and word counts, and the first mismatching word to the test controller.

## Interface
Parameters:
- LEADER_MODE, 1, data width multiplier; DW = LEADER_MODE*40
- TIMEOUT, 1024, idle cycles in RUN with FIFO empty before the check aborts (≥2)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- chk_start  in  1  pulse; load seed_in and patgen_cnt, begin a check
- seed_in  in  DW  first expected word
- patgen_cnt  in  8  number of words expected
- fifo_empty  in  1  checker FIFO empty
- fifo_rd_en  out  1  FIFO pop; data_in is valid in the same cycle
- data_in  in  DW  FIFO head word
- busy  out  1  state is RUN
- done  out  1  state is DONE; level signal
- pass  out  1  valid when done; 1 = all words matched, no timeout
- timeout  out  1  valid when done; aborted on idle
- rx_cnt  out  8  words consumed this check
- err_cnt  out  8  mismatches, saturating at 255
- first_err_data  out  DW  data_in at the first mismatch
- first_err_exp  out  DW  expected value at the first mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on chk_start with patgen_cnt≠0. IDLE → DONE on chk_start with patgen_cnt==0; pass=1, counts 0.
- On chk_start, from any state:
  - latch exp=seed_in and target=patgen_cnt
  - clear rx_cnt, err_cnt, first_err_*, timeout
  - clear the idle counter
- chk_start in RUN restarts the check. chk_start wins over a simultaneous last-word pop or timeout.
- RUN:
  - fifo_rd_en = !fifo_empty. No pops in IDLE or DONE, and none in the chk_start cycle.
  - On each pop: compare data_in to exp, then exp ← exp+1, modulo 2^DW (all-ones wraps to 0), and rx_cnt ← rx_cnt+1.
  - On mismatch: err_cnt increments, saturating at 255. first_err_* is captured only when err_cnt==0.
  - Expected value does not resync to received data.
- RUN → DONE on the pop where rx_cnt+1==target. pass = (err_cnt==0 and the final compare matched).
- Idle counter:
  - increments each RUN cycle with fifo_empty=1 and clears on every pop
  - on reaching TIMEOUT-1 while empty: RUN → DONE with timeout=1, pass=0
- DONE holds all results until chk_start or rst. Words arriving in DONE stay in the FIFO.

## Timing
- Reset (rst=1 at a clk edge): state IDLE; every output 0 (fifo_rd_en, busy, done, pass, timeout, rx_cnt, err_cnt, first_err_data, first_err_exp). The internal exp register is also 0. Reset mid-RUN aborts without reporting.
- chk_start in cycle T → busy=1 in T+1. First possible pop is in T+1.
- Compare is combinational on data_in. Counts and first_err_* update at the pop edge and are visible next cycle.
- Last pop in cycle T → done=1 and pass/err_cnt final in T+1; fifo_rd_en=0 in T+1.
- Sustained throughput: one word per cycle while the FIFO is non-empty.
- Timeout: after TIMEOUT consecutive empty RUN cycles, done=1 on the following cycle.

## Structure
- Shared package aximm_incr_pkg:
  - state enum (IDLE/RUN/DONE)
  - DW derivation from LEADER_MODE
  - count width localparam (8)
  - the generator also takes DW from this package
- One sub-module, aximm_chk_wdog: the idle counter, with parameter TIMEOUT and inputs clr, cnt_en; output expired.
- Everything else stays in aximm_incr_chk.

## Test plan
- Nominal: seed=0x00_0000_0010, patgen_cnt=8, words 0x10..0x17 back-to-back → done one cycle after the 8th pop; pass=1, rx_cnt=8, err_cnt=0.
- Single error: same setup, 4th word 0x99 → pass=0, err_cnt=1, first_err_data=0x99, first_err_exp=0x13; words 5..8 still compare clean against 0x14..0x17.
- Wrap and gaps: seed=0xFF_FFFF_FFFE, patgen_cnt=4, FIFO empty for 3 cycles between words → exp sequence FE, FF, 0, 1; pass=1; fifo_rd_en only when non-empty.
- Timeout: TIMEOUT=16, patgen_cnt=5, supply 2 words then hold empty → done with timeout=1, pass=0, rx_cnt=2, 16 cycles after the last pop.
- Zero/restart: patgen_cnt=0 → done, pass=1 next cycle. chk_start mid-RUN after 3 words → counts clear to 0 and exp reloads. rst mid-RUN → all outputs 0 the next cycle.
- Saturation: patgen_cnt=255, all words wrong → err_cnt=255, pass=0, first_err_* match the first word only.

Source files
------------

// File: rtl/aximm_incr_pkg.sv
// aximm_incr_pkg: shared types and widths for the AXI-MM incrementing pattern generator/checker
package aximm_incr_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam int LANE_W = 40;
   localparam int CNT_W = 8;
   function automatic int dw_of(input int leader_mode);
      return leader_mode * LANE_W;
   endfunction
endpackage

// File: rtl/aximm_chk_wdog.sv
// aximm_chk_wdog: idle-cycle watchdog, expired once TIMEOUT-1 empty cycles have been counted
module aximm_chk_wdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic cnt_en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : cnt_en ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
   assign expired = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/aximm_incr_chk.sv
// aximm_incr_chk: drains a FWFT FIFO and checks it against seed, seed+1, ...; reports counts and first error
module aximm_incr_chk
   import aximm_incr_pkg::*;
#(
   parameter int LEADER_MODE = 1,
   parameter int TIMEOUT = 1024,
   localparam int DW = dw_of(LEADER_MODE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_start,
   input  logic [DW-1:0]    seed_in,
   input  logic [CNT_W-1:0] patgen_cnt,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [DW-1:0]    data_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] rx_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [DW-1:0]    first_err_data,
   output logic [DW-1:0]    first_err_exp
);
   state_e           state_q, state_d;
   logic [DW-1:0]    exp_q, exp_d, fed_q, fed_d, fee_q, fee_d;
   logic [CNT_W-1:0] tgt_q, tgt_d, rx_q, rx_d, err_q, err_d;
   logic             pass_q, pass_d, to_q, to_d;
   logic             pop, mis, last, expired;

   assign busy       = state_q == RUN;
   assign done       = state_q == DONE;
   assign pop        = busy && !fifo_empty && !chk_start;
   assign fifo_rd_en = pop;
   assign mis        = data_in != exp_q;
   assign last       = rx_q + CNT_W'(1) == tgt_q;

   aximm_chk_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (pop || chk_start),
      .cnt_en  (busy && fifo_empty),
      .expired (expired)
   );

   // chk_start outranks a same-cycle last pop or timeout
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      tgt_d   = tgt_q;
      rx_d    = rx_q;
      err_d   = err_q;
      fed_d   = fed_q;
      fee_d   = fee_q;
      pass_d  = pass_q;
      to_d    = to_q;
      if (chk_start) begin
         state_d = (patgen_cnt == '0) ? DONE : RUN;
         exp_d   = seed_in;
         tgt_d   = patgen_cnt;
         rx_d    = '0;
         err_d   = '0;
         fed_d   = '0;
         fee_d   = '0;
         to_d    = 1'b0;
         pass_d  = patgen_cnt == '0;
      end else if (pop) begin
         exp_d = exp_q + DW'(1);
         rx_d  = rx_q + CNT_W'(1);
         if (mis) begin
            err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
            fed_d = (err_q == '0) ? data_in : fed_q;
            fee_d = (err_q == '0) ? exp_q : fee_q;
         end
         if (last) begin
            state_d = DONE;
            pass_d  = (err_q == '0) && !mis;
         end
      end else if (busy && fifo_empty && expired) begin
         state_d = DONE;
         to_d    = 1'b1;
         pass_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         exp_q   <= '0;
         tgt_q   <= '0;
         rx_q    <= '0;
         err_q   <= '0;
         fed_q   <= '0;
         fee_q   <= '0;
         pass_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         tgt_q   <= tgt_d;
         rx_q    <= rx_d;
         err_q   <= err_d;
         fed_q   <= fed_d;
         fee_q   <= fee_d;
         pass_q  <= pass_d;
         to_q    <= to_d;
      end
   end

   assign pass           = pass_q;
   assign timeout        = to_q;
   assign rx_cnt         = rx_q;
   assign err_cnt        = err_q;
   assign first_err_data = fed_q;
   assign first_err_exp  = fee_q;
endmodule

// File: tb/tb_aximm_incr_chk.sv
// tb_aximm_incr_chk: directed scoreboard bench for the incrementing-pattern checker (DW=40, TIMEOUT=16)
module tb_aximm_incr_chk;
   typedef struct {
      logic [7:0] rx;
      logic [7:0] err;
   } sb_t;

   logic        clk, rst, chk_start, fifo_empty, fifo_rd_en;
   logic        busy, done, pass, timeout, gap, popped;
   logic [39:0] seed_in, data_in, first_err_data, first_err_exp;
   logic [7:0]  patgen_cnt, rx_cnt, err_cnt;
   logic [39:0] fifo[$];
   sb_t         sb[$];
   logic [39:0] m_exp, m_fd, m_fe;
   logic [7:0]  m_rx, m_err;
   int          n_cmp = 0;
   int          n_err = 0;

   aximm_incr_chk #(.LEADER_MODE(1), .TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .chk_start      (chk_start),
      .seed_in        (seed_in),
      .patgen_cnt     (patgen_cnt),
      .fifo_empty     (fifo_empty),
      .fifo_rd_en     (fifo_rd_en),
      .data_in        (data_in),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .rx_cnt         (rx_cnt),
      .err_cnt        (err_cnt),
      .first_err_data (first_err_data),
      .first_err_exp  (first_err_exp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: drive FIFO at negedge, note any pop, then score that pop after the edge
   task automatic cyc();
      sb_t e;
      fifo_empty = gap || (fifo.size() == 0);
      data_in = (fifo.size() != 0) ? fifo[0] : '0;
      #1;
      popped = fifo_rd_en;
      if (fifo_empty) chk("rd_en_while_empty", {63'd0, fifo_rd_en}, 64'd0);
      if (popped && fifo.size() != 0) void'(fifo.pop_front());
      @(negedge clk);
      if (popped) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_pop: observed pop expected none");
         end else begin
            e = sb.pop_front();
            chk("pop_rx_cnt", {56'd0, rx_cnt}, {56'd0, e.rx});
            chk("pop_err_cnt", {56'd0, err_cnt}, {56'd0, e.err});
         end
      end
   endtask

   task automatic push(input logic [39:0] w);
      fifo.push_back(w);
      if (w !== m_exp) begin
         if (m_err == 8'd0) begin
            m_fd = w;
            m_fe = m_exp;
         end
         if (m_err != 8'hFF) m_err++;
      end
      m_exp++;
      m_rx++;
      sb.push_back('{rx: m_rx, err: m_err});
   endtask

   task automatic start(input logic [39:0] seed, input logic [7:0] cnt);
      seed_in = seed;
      patgen_cnt = cnt;
      chk_start = 1'b1;
      cyc();
      chk("no_pop_on_start", {63'd0, popped}, 64'd0);
      chk_start = 1'b0;
      fifo.delete();
      sb.delete();
      m_exp = seed;
      m_rx = '0;
      m_err = '0;
      m_fd = '0;
      m_fe = '0;
      chk("busy_after_start", {63'd0, busy}, {63'd0, cnt != 8'd0});
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && !done; i++) cyc();
      chk("done_within_budget", {63'd0, done}, 64'd1);
   endtask

   task automatic fin(input logic exp_pass, input logic exp_to);
      chk("done", {63'd0, done}, 64'd1);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      chk("pass", {63'd0, pass}, {63'd0, exp_pass});
      chk("timeout", {63'd0, timeout}, {63'd0, exp_to});
      chk("rx_cnt", {56'd0, rx_cnt}, {56'd0, m_rx});
      chk("err_cnt", {56'd0, err_cnt}, {56'd0, m_err});
      chk("first_err_data", {24'd0, first_err_data}, {24'd0, m_fd});
      chk("first_err_exp", {24'd0, first_err_exp}, {24'd0, m_fe});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"}, {63'd0, fifo_rd_en}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
      chk({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
      chk({tag, "_rx"}, {56'd0, rx_cnt}, 64'd0);
      chk({tag, "_err"}, {56'd0, err_cnt}, 64'd0);
      chk({tag, "_fed"}, {24'd0, first_err_data}, 64'd0);
      chk({tag, "_fee"}, {24'd0, first_err_exp}, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      chk_start = 1'b0;
      gap = 1'b0;
      seed_in = '0;
      patgen_cnt = '0;
      fifo_empty = 1'b1;
      data_in = '0;
      m_exp = '0; m_rx = '0; m_err = '0; m_fd = '0; m_fe = '0;
      @(negedge clk);
      cyc();
      cyc();
      rst = 1'b0;
      chk_all_zero("reset");
      // nominal back-to-back run
      start(40'h10, 8'd8);
      for (int i = 0; i < 8; i++) push(40'h10 + 40'(i));
      repeat (7) cyc();
      chk("nominal_not_done_early", {63'd0, done}, 64'd0);
      cyc();
      chk("nominal_rd_en_after_done", {63'd0, fifo_rd_en}, 64'd0);
      fin(1'b1, 1'b0);
      chk("nominal_rx8", {56'd0, rx_cnt}, 64'd8);
      // single error on the 4th word; later words still compare against 0x14..0x17
      start(40'h10, 8'd8);
      for (int i = 0; i < 8; i++) push(i == 3 ? 40'h99 : 40'h10 + 40'(i));
      run_until_done(20);
      fin(1'b0, 1'b0);
      chk("single_err_cnt", {56'd0, err_cnt}, 64'd1);
      chk("single_fed", {24'd0, first_err_data}, 64'h99);
      chk("single_fee", {24'd0, first_err_exp}, 64'h13);
      // wrap through all-ones with 3-cycle gaps
      start(40'hFF_FFFF_FFFE, 8'd4);
      for (int i = 0; i < 4; i++) begin
         push(40'hFF_FFFF_FFFE + 40'(i));
         gap = 1'b1;
         repeat (3) begin
            cyc();
            chk("gap_no_pop", {63'd0, popped}, 64'd0);
         end
         gap = 1'b0;
         cyc();
         chk("gap_pop", {63'd0, popped}, 64'd1);
      end
      fin(1'b1, 1'b0);
      // timeout: two words then sustained empty
      start(40'h20, 8'd5);
      push(40'h20);
      push(40'h21);
      cyc();
      cyc();
      repeat (15) cyc();
      chk("timeout_not_early", {63'd0, done}, 64'd0);
      cyc();
      fin(1'b0, 1'b1);
      chk("timeout_rx2", {56'd0, rx_cnt}, 64'd2);
      // zero-length check
      start(40'h55, 8'd0);
      fin(1'b1, 1'b0);
      // restart mid-run with a word waiting at the FIFO head
      start(40'h100, 8'd8);
      push(40'h100);
      push(40'h1FF);
      push(40'h102);
      push(40'h103);
      push(40'h104);
      repeat (3) cyc();
      chk("restart_pre_rx", {56'd0, rx_cnt}, 64'd3);
      chk("restart_pre_err", {56'd0, err_cnt}, 64'd1);
      start(40'h500, 8'd4);
      chk("restart_rx0", {56'd0, rx_cnt}, 64'd0);
      chk("restart_err0", {56'd0, err_cnt}, 64'd0);
      chk("restart_fed0", {24'd0, first_err_data}, 64'd0);
      for (int i = 0; i < 4; i++) push(40'h500 + 40'(i));
      run_until_done(10);
      fin(1'b1, 1'b0);
      // reset mid-run
      start(40'h0, 8'd8);
      push(40'h0);
      push(40'h1);
      push(40'h2);
      cyc();
      cyc();
      gap = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_all_zero("mid_reset");
      gap = 1'b0;
      fifo.delete();
      sb.delete();
      // every word wrong, 255 of them
      start(40'h100, 8'd255);
      for (int i = 0; i < 255; i++) push(40'h1100 + 40'(i));
      run_until_done(300);
      fin(1'b0, 1'b0);
      chk("sat_err255", {56'd0, err_cnt}, 64'd255);
      chk("sat_fed", {24'd0, first_err_data}, 64'h1100);
      chk("sat_fee", {24'd0, first_err_exp}, 64'h100);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
